// File: rtl/pe_act_skew_feeder_if.sv
// Handshake and array-side bundle between the activation source, the skew feeder and PE_array.
// stall_cnt is present only when PE_FEEDER_STALL_CNT_EN is defined.
interface pe_act_skew_feeder_if #(
    parameter int data_width      = 19,
    parameter int a_tile_row_size = 4
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [data_width*a_tile_row_size-1:0]   in_vec;
    logic                                    in_last;
    logic                                    start;
    logic [data_width*a_tile_row_size-1:0]   active_left;
    logic                                    w_compute;
    logic                                    busy;
    logic                                    done;
`ifdef PE_FEEDER_STALL_CNT_EN
    logic [15:0]                             stall_cnt;
`endif

    modport master (
        output in_valid, in_vec, in_last, start,
        input  in_ready, active_left, w_compute, busy, done
`ifdef PE_FEEDER_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  in_valid, in_vec, in_last, start,
        output in_ready, active_left, w_compute, busy, done
`ifdef PE_FEEDER_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/pe_act_skew_feeder.sv
// Buffers A-tile row vectors and releases them diagonally skewed into PE_array, then drains zeros.
// Latency: push->pop >= 1 cycle; a vector popped ending cycle k drives lane j in cycle k+1+j.
// Backpressure: in_ready low when FIFO full or after in_last until done; PE_FEEDER_STALL_CNT_EN adds stall_cnt.
module pe_act_skew_feeder #(
    parameter int data_width         = 19,
    parameter int a_tile_row_size    = 4,
    parameter int w_tile_column_size = 2,
    parameter int fifo_depth         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_act_skew_feeder_if.slave   bus
);
    localparam int vec_w     = data_width * a_tile_row_size;
    localparam int ptr_w     = $clog2(fifo_depth);
    localparam int cnt_w     = ptr_w + 1;
    localparam int drain_len = a_tile_row_size - 1 + w_tile_column_size;
    localparam int drain_w   = $clog2(drain_len + 1);

    typedef struct packed {
        logic               last;
        logic [vec_w-1:0]   vec;
    } entry_t;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    entry_t             mem [fifo_depth];
    entry_t             head;
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               last_seen;
    logic               drain_end;
    state_t             state;
    state_t             state_nxt;
    logic [drain_w-1:0] drain_cnt;
    logic               done_q;
    logic [vec_w-1:0]   feed_vec;
    logic [vec_w-1:0]   skew_out;

    assign fifo_full    = (count == cnt_w'(fifo_depth));
    assign fifo_empty   = (count == '0);
    assign head         = mem[rd_ptr];
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == STREAM) && !fifo_empty;
    assign drain_end    = (state == DRAIN) && (drain_cnt == drain_w'(1));
    assign bus.in_ready = !fifo_full && !last_seen;
    assign bus.done     = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_vec};
        end
    end

    // last_seen closes the intake once the tile's final vector is in, until the drain completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_seen <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drain_end) begin
                last_seen <= 1'b0;
            end else if (push && bus.in_last) begin
                last_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = STREAM;
            STREAM:  if (pop && head.last) state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // empty FIFO in STREAM feeds a zero bubble so the skew keeps marching
    always_comb begin
        bus.w_compute = 1'b0;
        bus.busy      = 1'b0;
        feed_vec      = '0;
        case (state)
            STREAM: begin
                bus.w_compute = 1'b1;
                bus.busy      = 1'b1;
                if (pop) begin
                    feed_vec = head.vec;
                end
            end
            DRAIN: begin
                bus.w_compute = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            if (pop && head.last) begin
                drain_cnt <= drain_w'(drain_len);
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            done_q <= drain_end;
        end
    end

    for (genvar j = 0; j < a_tile_row_size; j++) begin : g_lane
        logic [data_width-1:0] sr [j+1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < j + 1; k++) sr[k] <= '0;
            end else if (state == IDLE) begin
                for (int k = 0; k < j + 1; k++) sr[k] <= '0;
            end else begin
                sr[0] <= feed_vec[j*data_width +: data_width];
                for (int k = 1; k < j + 1; k++) sr[k] <= sr[k-1];
            end
        end

        assign skew_out[j*data_width +: data_width] = sr[j];
    end

    assign bus.active_left = skew_out;

`ifdef PE_FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state == IDLE) && bus.start) begin
            stall_q <= '0;
        end else if ((state == STREAM) && fifo_empty && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    // no bubble accounting in the default build
`endif
endmodule

// File: doc/pe_act_skew_feeder.md
# pe_act_skew_feeder

Activation front-end that sits directly upstream of `PE_array` and drives its `active_left` bus and `w_compute` strobe. It buffers row vectors of an A tile arriving over a valid/ready handshake and releases them into the array with the diagonal skew a systolic array needs: lane j lags lane 0 by j cycles. After the final vector it drains zeros so partial sums can flush out of `out_sum`, then pulses `done`.

## Interface
- `data_width`, 19: width of one activation element.
- `a_tile_row_size`, 4: lanes per vector; equals the `PE_array` row count.
- `w_tile_column_size`, 2: `PE_array` column count; sets the drain length.
- `fifo_depth`, 8: vector FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream vector valid.
- `in_ready`  out  1  feeder can accept a vector.
- `in_vec`  in  data_width*a_tile_row_size  vector; lane j is bits [j*data_width +: data_width].
- `in_last`  in  1  marks the final vector of the tile; sampled with the handshake.
- `start`  in  1  single-cycle pulse: weights are loaded, begin streaming.
- `active_left`  out  data_width*a_tile_row_size  skewed activations to `PE_array`.
- `w_compute`  out  1  compute enable to `PE_array`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  single-cycle pulse when the tile has fully drained.

## Operation
- The FIFO holds `fifo_depth` entries of {`in_last`, `in_vec`}.
- A push happens when `in_valid && in_ready`.
- `in_ready` = FIFO not full AND no `in_last` vector accepted yet in the current tile. After `in_last` is accepted, `in_ready` stays 0 until `done`.
- There is no full-FIFO pass-through. A push and a pop in the same cycle are legal whenever the FIFO is not full.
- Pointers wrap modulo `fifo_depth`. Occupancy is tracked by a count register of width log2(`fifo_depth`)+1.

State machine:
- IDLE:
  - Pushes are allowed; nothing is popped.
  - `w_compute`=0.
  - `start` moves the state to STREAM. `start` is ignored in every other state.
- STREAM:
  - `w_compute`=1.
  - Each cycle, pop if the FIFO is non-empty and feed the popped vector into the skew stage.
  - If the FIFO is empty, feed an all-zero bubble vector instead. The skew keeps advancing.
  - Popping an entry whose last flag is set moves the state to DRAIN and loads `drain_cnt` with D = `a_tile_row_size`-1+`w_tile_column_size`.
- DRAIN:
  - `w_compute`=1; zero vectors feed the skew stage.
  - `drain_cnt` decrements every cycle.
  - When the cycle with `drain_cnt`==1 ends, the state goes to IDLE and `done`=1 for exactly one cycle.

Skew stage:
- Lane j is a j+1-deep shift register. Its input is lane j of the fed vector; its output is `active_left` lane j.
- All lanes shift every cycle in STREAM and DRAIN.
- In IDLE the shift registers are loaded with zeros.
- Data width is passed through unchanged; there is no arithmetic.

## Timing
- Reset values:
  - `in_ready`=1, `active_left`=0, `w_compute`=0, `busy`=0, `done`=0.
  - FIFO empty, `drain_cnt`=0, all skew registers 0, state IDLE.
- Push to earliest pop: a vector pushed at edge e can be popped at edge e+1 at the earliest (STREAM only).
- Lane latency: a vector popped at the edge ending cycle k appears on lane j during cycle k+1+j.
- `w_compute`:
  - Rises in the cycle after the `start` edge.
  - Stays 1 through STREAM plus D DRAIN cycles.
  - Falls in the same cycle that `done` is 1.
- `start` arriving with an empty FIFO: STREAM emits bubbles until data arrives. This is not an error.
- `start` and a push in the same cycle: the pushed vector is poppable from the next cycle.
- Reset asserted mid-operation clears everything immediately, with no drain and no `done` pulse.

## Configuration
- `PE_FEEDER_STALL_CNT_EN` defined:
  - Adds output port `stall_cnt` (16 bits).
  - It counts STREAM cycles in which a bubble was injected.
  - It saturates at 16'hFFFF and clears on `rst` and on `start`.
- Not defined: the port, the counter and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use the defaults, so D=5.
- Reset with `in_valid`=1 held: `active_left`=0, `w_compute`=0, `in_ready`=1, no push recorded.
- Push V0 with lanes {1,2,3,4}, `in_last`=1, then pulse `start`:
  - Pop at the first STREAM edge.
  - Lane 0=1 in cycle k+1, lane 1=2 in cycle k+2, lane 2=3 in cycle k+3, lane 3=4 in cycle k+4.
  - `done` pulses after 1 STREAM + 5 DRAIN cycles; `w_compute` is high for exactly 6 cycles.
- Push 8 vectors without `start`: `in_ready` falls after the 8th push. A 9th `in_valid` is not accepted.
- `start` with an empty FIFO, then push 2 vectors (the last with `in_last`) 3 cycles later:
  - 3 bubble cycles produce zeros on all lanes.
  - With `PE_FEEDER_STALL_CNT_EN` defined, `stall_cnt`=3.
- Assert `rst` during DRAIN when `drain_cnt`=2: all outputs return to reset values in the same cycle, and `done` never pulses.
- Accept `in_last`, then hold `in_valid`=1 with a new vector: `in_ready` stays 0 until `done`, then returns to 1.
